cga_fill: RTL and testbench

- Drawing engine that writes into the 4bpp packed framebuffer scanned out by the CGA display path.
- Layout is 640x480, 2 pixels per byte, 320 bytes per line, byte address = (x>>1) + y*320.
- Even x occupies data[7:4]; odd x occupies data[3:0].
- Accepts a rectangle-fill command (a single pixel is the degenerate case) and issues byte writes to the video RAM port, using read-modify-write for half-covered bytes.

---
 rtl/cga_pkg.sv | 35 +++
 rtl/cga_nibble_merge.sv | 24 ++
 rtl/cga_fill.sv | 213 +++++++++++++++++++++
 tb/tb_cga_fill.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
// ============================================================================
//  Module   : cga_pkg
//  Purpose  : Shared geometry, color and FSM types for the CGA fill engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cga_pkg;

    localparam int H_PIXELS       = 640;
    localparam int V_LINES        = 480;
    localparam int BYTES_PER_LINE = H_PIXELS / 2;
    localparam int ADDR_W         = 18;

    typedef logic [3:0] color_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        READ   = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } state_t;

    // y * 320 as y*256 + y*64, avoiding a multiplier.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [8:0] y);
        logic [ADDR_W-1:0] w_y;
        w_y = {{(ADDR_W-9){1'b0}}, y};
        return (w_y << 8) + (w_y << 6);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cga_nibble_merge.sv
// ============================================================================
//  Module   : cga_nibble_merge
//  Purpose  : Replaces the covered nibble(s) of a packed 4bpp byte with color.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cga_nibble_merge
    import cga_pkg::*;
(
    input  logic       i_hi,
    input  logic       i_lo,
    input  color_t     i_color,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    // Even pixel lives in the upper nibble, odd pixel in the lower.
    assign o_data = {i_hi ? i_color : i_data[7:4],
                     i_lo ? i_color : i_data[3:0]};

endmodule

`default_nettype wire

// File: rtl/cga_fill.sv
// ============================================================================
//  Module   : cga_fill
//  Purpose  : Rectangle fill into the 4bpp packed framebuffer, RMW on half bytes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cga_fill
    import cga_pkg::*;
(
    input  logic              clock_25,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        x0,
    input  logic [8:0]        y0,
    input  logic [9:0]        x1,
    input  logic [8:0]        y1,
    input  color_t            color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              we
);

    localparam logic [9:0]        c_X_MAX  = 10'(H_PIXELS - 1);
    localparam logic [8:0]        c_Y_MAX  = 9'(V_LINES - 1);
    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(BYTES_PER_LINE);

    state_t            r_state, w_state_n;
    logic [9:0]        r_x0, r_x1;
    logic [8:0]        r_y0, r_y1, r_cur_y, w_cur_y_n;
    color_t            r_color;
    logic [8:0]        r_bx, w_bx_n;
    logic [ADDR_W-1:0] r_row_base, w_row_base_n;

    logic              r_cmd_ready, w_cmd_ready_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              r_we, w_we_n;
    logic [ADDR_W-1:0] r_address, w_address_n;
    logic [7:0]        r_data_out, w_data_out_n;
    logic              w_latch, w_dispatch;

    logic [9:0]        w_x1c;
    logic [8:0]        w_y1c;
    logic              w_empty, w_row_end, w_last_row;
    logic [8:0]        w_cand_bx;
    logic [ADDR_W-1:0] w_cand_row, w_cand_addr;
    logic              w_hi, w_lo;
    logic [7:0]        w_merged;

    assign w_x1c      = (r_x1 > c_X_MAX) ? c_X_MAX : r_x1;
    assign w_y1c      = (r_y1 > c_Y_MAX) ? c_Y_MAX : r_y1;
    assign w_empty    = (r_x0 > w_x1c) || (r_y0 > w_y1c) ||
                        (r_x0 > c_X_MAX) || (r_y0 > c_Y_MAX);
    assign w_row_end  = (r_bx >= w_x1c[9:1]);
    assign w_last_row = (r_cur_y >= w_y1c);

    // Candidate byte: the one the next dispatch (or the pending RMW) targets.
    always_comb begin
        w_cand_bx  = r_bx;
        w_cand_row = r_row_base;
        if (r_state == SETUP) begin
            w_cand_bx  = r_x0[9:1];
            w_cand_row = row_offset(r_y0);
        end else if (r_state == WRITE) begin
            if (!w_row_end) begin
                w_cand_bx = r_bx + 9'd1;
            end else begin
                w_cand_bx  = r_x0[9:1];
                w_cand_row = r_row_base + c_STRIDE;
            end
        end
    end

    assign w_hi        = ({w_cand_bx, 1'b0} >= r_x0);
    assign w_lo        = ({w_cand_bx, 1'b1} <= w_x1c);
    assign w_cand_addr = w_cand_row + {{(ADDR_W-9){1'b0}}, w_cand_bx};

    cga_nibble_merge u_merge (
        .i_hi    (w_hi),
        .i_lo    (w_lo),
        .i_color (r_color),
        .i_data  (data_in),
        .o_data  (w_merged)
    );

    always_comb begin
        w_state_n     = r_state;
        w_cmd_ready_n = r_cmd_ready;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;
        w_we_n        = 1'b0;
        w_address_n   = r_address;
        w_data_out_n  = r_data_out;
        w_bx_n        = r_bx;
        w_row_base_n  = r_row_base;
        w_cur_y_n     = r_cur_y;
        w_latch       = 1'b0;
        w_dispatch    = 1'b0;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_latch       = 1'b1;
                    w_state_n     = SETUP;
                    w_cmd_ready_n = 1'b0;
                    w_busy_n      = 1'b1;
                end
            end
            SETUP: begin
                w_cur_y_n = r_y0;
                if (w_empty) begin
                    w_state_n = FINISH;
                end else begin
                    w_dispatch = 1'b1;
                end
            end
            READ: begin
                w_state_n = WAIT;
            end
            WAIT: begin
                w_state_n    = WRITE;
                w_we_n       = 1'b1;
                w_data_out_n = w_merged;
            end
            WRITE: begin
                if (!w_row_end) begin
                    w_dispatch = 1'b1;
                end else if (!w_last_row) begin
                    w_cur_y_n  = r_cur_y + 9'd1;
                    w_dispatch = 1'b1;
                end else begin
                    w_state_n = FINISH;
                end
            end
            FINISH: begin
                w_state_n     = IDLE;
                w_done_n      = 1'b1;
                w_busy_n      = 1'b0;
                w_cmd_ready_n = 1'b1;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Fully covered bytes go straight to WRITE; half bytes need a read first.
        if (w_dispatch) begin
            w_bx_n       = w_cand_bx;
            w_row_base_n = w_cand_row;
            w_address_n  = w_cand_addr;
            if (w_hi && w_lo) begin
                w_state_n    = WRITE;
                w_we_n       = 1'b1;
                w_data_out_n = w_merged;
            end else begin
                w_state_n = READ;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_address   <= '0;
            r_data_out  <= '0;
            r_bx        <= '0;
            r_row_base  <= '0;
            r_cur_y     <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_color     <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cmd_ready <= w_cmd_ready_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_we        <= w_we_n;
            r_address   <= w_address_n;
            r_data_out  <= w_data_out_n;
            r_bx        <= w_bx_n;
            r_row_base  <= w_row_base_n;
            r_cur_y     <= w_cur_y_n;
            if (w_latch) begin
                r_x0    <= x0;
                r_x1    <= x1;
                r_y0    <= y0;
                r_y1    <= y1;
                r_color <= color;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign we        = r_we;
    assign address   = r_address;
    assign data_out  = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_cga_fill.sv
// ============================================================================
//  Module   : tb_cga_fill
//  Purpose  : Directed self-checking bench for cga_fill with a byte RAM model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cga_fill;
    import cga_pkg::*;

    logic              clock_25 = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        x0, x1;
    logic [8:0]        y0, y1;
    logic [3:0]        color;
    logic              busy, done, we;
    logic [ADDR_W-1:0] address;
    logic [7:0]        data_in, data_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wlog[$];

    logic [7:0] mem [0:153599];

    cga_fill dut (
        .clock_25  (clock_25),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .we        (we)
    );

    always #5 clock_25 = ~clock_25;

    // Synchronous RAM: read data one cycle after the address, writes logged.
    always @(posedge clock_25) begin
        cyc = cyc + 1;
        data_in <= mem[address];
        if (we) begin
            mem[address] <= data_out;
            wlog.push_back('{int'(address), int'(data_out), cyc});
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                        input logic [3:0] c);
        @(negedge clock_25);
        wlog.delete();
        cmd_valid = 1'b1;
        x0 = 10'(ax0); y0 = 9'(ay0); x1 = 10'(ax1); y1 = 9'(ay1); color = c;
        @(posedge clock_25);
        #1;
        cmd_valid = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        check("accept_busy", int'(busy), 1);
    endtask

    // Edges after the accept edge until done is seen high.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clock_25);
            #1;
            n++;
            if (done) break;
        end
    endtask

    int n, bad_a, bad_d, bad_c;
    int exp_a [6] = '{0, 1, 2, 320, 321, 322};
    int exp_d [6] = '{8'h0F, 8'hFF, 8'hF0, 8'h0F, 8'hFF, 8'hF0};

    initial begin
        for (int i = 0; i < 153600; i++) mem[i] = 8'h00;
        reset = 1'b1; cmd_valid = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(posedge clock_25);
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_we",    int'(we), 0);
        check("rst_addr",  int'(address), 0);
        check("rst_data",  int'(data_out), 0);
        @(negedge clock_25);
        reset = 1'b0;

        // Single pixel, upper nibble RMW
        mem[0] = 8'h37;
        send(0, 0, 0, 0, 4'hA);
        wait_done(n);
        check("px_done_lat", n, 5);
        check("px_nwr", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check("px_addr", wlog[0].addr, 0);
            check("px_data", wlog[0].data, 8'hA7);
        end
        @(posedge clock_25); #1;
        check("px_ready", int'(cmd_ready), 1);

        // Bottom-right pixel, lower nibble RMW
        mem[153599] = 8'hC3;
        send(639, 479, 639, 479, 4'h5);
        wait_done(n);
        check("br_done_lat", n, 5);
        check("br_nwr", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check("br_addr", wlog[0].addr, 153599);
            check("br_data", wlog[0].data, 8'hC5);
        end

        // Mixed row: RMW / direct / RMW on two lines
        for (int i = 0; i < 6; i++) mem[exp_a[i]] = 8'h00;
        send(1, 0, 4, 1, 4'hF);
        wait_done(n);
        check("mix_done_lat", n, 16);
        check("mix_nwr", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            check($sformatf("mix_addr%0d", i), wlog[i].addr, exp_a[i]);
            check($sformatf("mix_data%0d", i), wlog[i].data, exp_d[i]);
        end

        // Full line with x1 clamped to 639
        send(0, 10, 1000, 10, 4'h1);
        wait_done(n);
        check("line_done_lat", n, 322);
        check("line_nwr", wlog.size(), 320);
        bad_a = 0; bad_d = 0; bad_c = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (wlog[i].addr != 3200 + i) bad_a++;
            if (wlog[i].data != 8'h11) bad_d++;
            if (wlog[i].cyc != wlog[0].cyc + i) bad_c++;
        end
        check("line_bad_addr", bad_a, 0);
        check("line_bad_data", bad_d, 0);
        check("line_not_consecutive", bad_c, 0);

        // Empty and out-of-range commands
        send(5, 5, 4, 5, 4'h7);
        wait_done(n);
        check("empty_done_lat", n, 2);
        check("empty_nwr", wlog.size(), 0);
        check("empty_ready", int'(cmd_ready), 1);
        send(700, 0, 710, 0, 4'h7);
        wait_done(n);
        check("oor_done_lat", n, 2);
        check("oor_nwr", wlog.size(), 0);
        check("oor_ready", int'(cmd_ready), 1);

        // Reset mid-fill
        send(0, 0, 639, 479, 4'h2);
        n = 0;
        while (wlog.size() < 100 && n < 1000) begin
            @(posedge clock_25); #1; n++;
        end
        check("rmf_reached100", int'(wlog.size() >= 100), 1);
        reset = 1'b1;
        @(posedge clock_25); #1;
        check("rmf_we",    int'(we), 0);
        check("rmf_busy",  int'(busy), 0);
        check("rmf_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        wlog.delete();
        repeat (5) @(posedge clock_25);
        #1;
        check("rmf_no_writes", wlog.size(), 0);

        mem[641] = 8'h6B;
        send(3, 2, 3, 2, 4'h9);
        wait_done(n);
        check("post_done_lat", n, 5);
        check("post_nwr", wlog.size(), 1);
        if (wlog.size() > 0) begin
            check("post_addr", wlog[0].addr, 641);
            check("post_data", wlog[0].data, 8'h69);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
